seg_scan_ctrl: RTL and testbench

- Scan controller for the multiplexed 7-segment display: holds one hex nibble per digit, time-multiplexes digit select and segment pattern, and inserts a blanking slot between digits to suppress ghosting.
- Digit values are written through a valid/ready port into a shadow buffer.
- A commit request copies the shadow buffer to the active buffer only at a frame boundary, so a frame never mixes old and new data.
- Sits between the user or control logic and the physical led/del pins.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_scan_ctrl_if.sv | 36 +++
 rtl/seg_scan_ctrl_decode.sv | 12 +
 rtl/seg_scan_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks: scan states,
// nibble-to-segment table and led bit positions.
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } state_e;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam int         DP_BIT    = 7;

   // Segment patterns, bit order g..a, active-high.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit write / commit port of the segment scan controller.
// With SEG_DP_EN defined, a per-digit decimal-point bit travels with the data.
interface seg_scan_ctrl_if;

   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;
   logic       commit;
`ifdef SEG_DP_EN
   logic       wr_dp;
`endif

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      output commit,
`ifdef SEG_DP_EN
      output wr_dp,
`endif
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      input  commit,
`ifdef SEG_DP_EN
      input  wr_dp,
`endif
      output wr_ready
   );

endinterface

// File: rtl/seg_scan_ctrl_decode.sv
// Combinational hex nibble to 7-segment pattern (g..a, active-high).
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   // Plain table lookup.
   assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with shadow/active digit buffers,
// frame-aligned commit and an inter-digit blanking slot.
// Optional macro SEG_DP_EN adds a double-buffered decimal point per digit.
//
// state | meaning
// IDLE  | display off, del = 0, counters held at 0
// SHOW  | driving decoded pattern of digit del
// BLANK | all segments off at the tail of the digit slot
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 3,
   parameter int CLK_DIV      = 8,
   parameter int BLANK_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   seg_scan_ctrl_if.slave      wr,
   output logic [7:0]          led,
   output logic [2:0]          del,
   output logic                frame_done
);

   localparam int             CW        = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0]  SLOT_LOAD = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]  BLANK_TC  = CW'(BLANK_CYCLES);
   localparam logic [2:0]     LAST_DIG  = 3'(NUM_DIGITS - 1);

   state_e                         state_q, state_d;
   logic [2:0]                     del_q, del_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic [7:0]                     led_q, led_d;
   logic                           pend_q, pend_d;
   logic [NUM_DIGITS-1:0][3:0]     shd_nib_q, shd_nib_d, act_nib_q, act_nib_d;
   logic [NUM_DIGITS-1:0]          shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;

   logic       wr_dp_w;
   logic       wr_acc;
   logic       slot_end;
   logic       at_boundary;
   logic       copy;
   logic [2:0] next_dig;
   logic [2:0] tgt;
   logic [3:0] nib_sel;
   logic       dp_sel;
   logic [6:0] seg_w;
   logic [7:0] show_pat;

`ifdef SEG_DP_EN
   assign wr_dp_w = wr.wr_dp;
`else
   assign wr_dp_w = 1'b0;
`endif

   // cnt_q is a down-counter; zero marks the last cycle of a digit slot.
   assign slot_end    = (cnt_q == '0);
   assign at_boundary = (state_q != IDLE) && (del_q == LAST_DIG) && slot_end;
   assign copy        = pend_q && ((state_q == IDLE) || at_boundary);
   assign next_dig    = (del_q == LAST_DIG) ? 3'd0 : del_q + 3'd1;
   assign wr_acc      = wr.wr_valid & ~pend_q;

   assign wr.wr_ready = ~pend_q;
   assign led         = led_q;
   assign del         = del_q;
   assign frame_done  = at_boundary;

   // Shadow writes, commit request and frame-aligned shadow-to-active copy.
   always_comb begin
      shd_nib_d = shd_nib_q;
      shd_dp_d  = shd_dp_q;
      act_nib_d = act_nib_q;
      act_dp_d  = act_dp_q;
      pend_d    = pend_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (wr_acc && (wr.wr_addr == 3'(i))) begin
            shd_nib_d[i] = wr.wr_data;
            shd_dp_d[i]  = wr_dp_w;
         end
      end
      if (copy) begin
         act_nib_d = shd_nib_q;
         act_dp_d  = shd_dp_q;
         pend_d    = 1'b0;
      end else if (wr.commit) begin
         pend_d    = 1'b1;
      end
   end

   // Pick the digit shown next cycle; on a copy edge the new data is already used.
   always_comb begin
      tgt     = 3'd0;
      nib_sel = 4'h0;
      dp_sel  = 1'b0;
      if (state_q != IDLE) begin
         tgt = slot_end ? next_dig : del_q;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (tgt == 3'(i)) begin
            nib_sel = copy ? shd_nib_q[i] : act_nib_q[i];
            dp_sel  = copy ? shd_dp_q[i]  : act_dp_q[i];
         end
      end
   end

   seg_decode u_dec (
      .nib_i (nib_sel),
      .seg_o (seg_w)
   );

   assign show_pat = {dp_sel, seg_w};

   // Next-state, slot counter, digit index and registered led pattern.
   always_comb begin
      state_d = state_q;
      del_d   = del_q;
      cnt_d   = cnt_q;
      led_d   = SEG_BLANK;
      case (state_q)
         IDLE: begin
            del_d = 3'd0;
            cnt_d = '0;
            if (en) begin
               state_d = SHOW;
               cnt_d   = SLOT_LOAD;
               led_d   = show_pat;
            end
         end
         SHOW, BLANK: begin
            if (!en) begin
               state_d = IDLE;
               del_d   = 3'd0;
               cnt_d   = '0;
            end else if (slot_end) begin
               state_d = SHOW;
               del_d   = next_dig;
               cnt_d   = SLOT_LOAD;
               led_d   = show_pat;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q <= BLANK_TC) begin
                  state_d = BLANK;
               end else begin
                  state_d = SHOW;
                  led_d   = show_pat;
               end
            end
         end
         default: begin
            state_d = IDLE;
            del_d   = 3'd0;
            cnt_d   = '0;
         end
      endcase
   end

   // Scan FSM and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         del_q   <= 3'd0;
         cnt_q   <= '0;
         led_q   <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         del_q   <= del_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
      end
   end

   // Digit buffers and commit flag; a pending commit is dropped by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shd_nib_q <= '0;
         shd_dp_q  <= '0;
         act_nib_q <= '0;
         act_dp_q  <= '0;
         pend_q    <= 1'b0;
      end else begin
         shd_nib_q <= shd_nib_d;
         shd_dp_q  <= shd_dp_d;
         act_nib_q <= act_nib_d;
         act_dp_q  <= act_dp_d;
         pend_q    <= pend_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at default parameters (24-cycle frame).
module tb_seg_scan_ctrl;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] led;
   logic [2:0] del;
   logic       frame_done;

   int n_chk  = 0;
   int n_fail = 0;

   seg_scan_ctrl_if wr_if ();

   seg_scan_ctrl u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .wr         (wr_if),
      .led        (led),
      .del        (del),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Expected outputs at cycle k (0..23) of a frame showing patterns e0/e1/e2.
   task automatic check_cycle(input int k, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2);
      logic [7:0] el;
      int         d;
      d  = k / 8;
      el = (d == 0) ? e0 : (d == 1) ? e1 : e2;
      if ((k % 8) == 7) el = 8'h00;
      chk($sformatf("del k=%0d", k), 32'(del), 32'(d));
      chk($sformatf("led k=%0d", k), 32'(led), 32'(el));
      chk($sformatf("frame_done k=%0d", k), 32'(frame_done), (k == 23) ? 32'd1 : 32'd0);
   endtask

   task automatic wr_dig(input logic [2:0] a, input logic [3:0] d, input logic dp);
      chk("wr_ready before write", 32'(wr_if.wr_ready), 32'd1);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_addr  = a;
      wr_if.wr_data  = d;
`ifdef SEG_DP_EN
      wr_if.wr_dp    = dp;
`else
      if (dp) $display("note: dp ignored in this build");
`endif
      @(negedge clk);
      wr_if.wr_valid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      en             = 1'b0;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_addr  = 3'd0;
      wr_if.wr_data  = 4'h0;
      wr_if.commit   = 1'b0;
`ifdef SEG_DP_EN
      wr_if.wr_dp    = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("reset led", 32'(led), 32'h00);
      chk("reset del", 32'(del), 32'd0);
      chk("reset frame_done", 32'(frame_done), 32'd0);
      chk("reset wr_ready", 32'(wr_if.wr_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Load 1, 0, 9 and commit while idle.
      wr_dig(3'd0, 4'h1, 1'b0);
      wr_dig(3'd1, 4'h0, 1'b0);
      wr_dig(3'd2, 4'h9, 1'b0);
      wr_if.commit = 1'b1;
      @(negedge clk);
      wr_if.commit = 1'b0;
      chk("idle commit pending", 32'(wr_if.wr_ready), 32'd0);
      @(negedge clk);
      chk("idle commit copied", 32'(wr_if.wr_ready), 32'd1);
      chk("idle led", 32'(led), 32'h00);
      en = 1'b1;
      @(negedge clk);

      // Frame 1.
      for (int k = 0; k < 24; k++) begin
         check_cycle(k, 8'h06, 8'h3F, 8'h6F);
         @(negedge clk);
      end

      // Frame 2: write digit 1 = A with commit at del=1; held write while pending.
      for (int k = 0; k < 24; k++) begin
         check_cycle(k, 8'h06, 8'h3F, 8'h6F);
         chk($sformatf("wr_ready f2 k=%0d", k), 32'(wr_if.wr_ready), (k >= 9) ? 32'd0 : 32'd1);
         if (k == 8) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_addr  = 3'd1;
            wr_if.wr_data  = 4'hA;
            wr_if.commit   = 1'b1;
         end else if (k == 9) begin
            wr_if.wr_valid = 1'b0;
            wr_if.commit   = 1'b0;
         end else if (k == 10) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_addr  = 3'd1;
            wr_if.wr_data  = 4'h5;
         end else if (k == 20) begin
            wr_if.wr_valid = 1'b0;
         end
         @(negedge clk);
      end

      // Frame 3: new data live; out-of-range write then commit.
      chk("wr_ready after copy", 32'(wr_if.wr_ready), 32'd1);
      for (int k = 0; k < 24; k++) begin
         check_cycle(k, 8'h06, 8'h77, 8'h6F);
         if (k == 2) begin
            chk("wr_ready addr5", 32'(wr_if.wr_ready), 32'd1);
            wr_if.wr_valid = 1'b1;
            wr_if.wr_addr  = 3'd5;
            wr_if.wr_data  = 4'h3;
         end else if (k == 3) begin
            wr_if.wr_valid = 1'b0;
         end else if (k == 4) begin
            wr_if.commit   = 1'b1;
         end else if (k == 5) begin
            wr_if.commit   = 1'b0;
         end
         @(negedge clk);
      end

      // Frame 4: unchanged display, drop en at del=1 cycle 3.
      for (int k = 0; k < 12; k++) begin
         check_cycle(k, 8'h06, 8'h77, 8'h6F);
         if (k == 11) en = 1'b0;
         @(negedge clk);
      end
      chk("en drop led", 32'(led), 32'h00);
      chk("en drop del", 32'(del), 32'd0);
      chk("en drop frame_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      chk("idle hold led", 32'(led), 32'h00);
      chk("idle hold del", 32'(del), 32'd0);
      en = 1'b1;
      @(negedge clk);

      // Frame 5: fresh full slots after re-enable.
      for (int k = 0; k < 24; k++) begin
         check_cycle(k, 8'h06, 8'h77, 8'h6F);
         @(negedge clk);
      end

      // Frame 6: commit pending, reset in digit 1 blank cycle.
      for (int k = 0; k < 16; k++) begin
         check_cycle(k, 8'h06, 8'h77, 8'h6F);
         if (k == 2) wr_if.commit = 1'b1;
         if (k == 3) begin
            wr_if.commit = 1'b0;
            chk("pending before reset", 32'(wr_if.wr_ready), 32'd0);
         end
         if (k < 15) @(negedge clk);
      end
      #1 rst_n = 1'b0;
      en = 1'b0;
      #1;
      chk("async rst led", 32'(led), 32'h00);
      chk("async rst del", 32'(del), 32'd0);
      chk("async rst wr_ready", 32'(wr_if.wr_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 24; k++) begin
            check_cycle(k, 8'h3F, 8'h3F, 8'h3F);
            chk($sformatf("wr_ready post rst f=%0d k=%0d", f, k), 32'(wr_if.wr_ready), 32'd1);
            @(negedge clk);
         end
      end

`ifdef SEG_DP_EN
      // Digit 2 = 9 with decimal point.
      wr_dig(3'd2, 4'h9, 1'b1);
      wr_if.commit = 1'b1;
      @(negedge clk);
      wr_if.commit = 1'b0;
      for (int k = 2; k < 24; k++) @(negedge clk);
      for (int k = 0; k < 24; k++) begin
         check_cycle(k, 8'h3F, 8'h3F, 8'hEF);
         @(negedge clk);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
